// File: rtl/stream_demux_nway_if.sv
// Avalon-ST bundle for the one-to-N stream demultiplexer.
// The "slave" modport is the demux's own view: it receives the input beat
// and the per-channel sink handshake, and it drives in_ready and the outputs.
// The "master" modport is the surrounding environment (source plus sinks).
interface stream_demux_nway_if #(
    parameter int DW    = 512,
    parameter int EW    = 6,
    parameter int N_OUT = 4
);
    logic [DW-1:0]       in_data;
    logic                in_valid;
    logic                in_sop;
    logic                in_eop;
    logic [EW-1:0]       in_empty;
    logic                in_ready;

    logic [N_OUT*DW-1:0] out_data;
    logic [N_OUT-1:0]    out_valid;
    logic [N_OUT-1:0]    out_sop;
    logic [N_OUT-1:0]    out_eop;
    logic [N_OUT*EW-1:0] out_empty;
    logic [N_OUT-1:0]    out_ready;
    logic [N_OUT-1:0]    out_almost_full;

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_empty,
        output in_ready,
        output out_data, out_valid, out_sop, out_eop, out_empty,
        input  out_ready, out_almost_full
    );

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_empty,
        input  in_ready,
        input  out_data, out_valid, out_sop, out_eop, out_empty,
        output out_ready, out_almost_full
    );
endinterface

// File: rtl/stream_demux_nway.sv
// stream_demux_nway: routes Avalon-ST packets to one of N_OUT channels using
// a channel tag carried in the SOP beat. One shared output register stage;
// only the valid strobe is steered, data/sop/eop/empty fan out to all channels.
// Packets with an out-of-range tag are swallowed and counted.
// Optional feature macro STREAM_DEMUX_DROP_EN: packets whose target sink
// reports almost-full at SOP time are dropped whole and counted in drop_cnt.
module stream_demux_nway #(
    parameter int DW      = 512,
    parameter int EW      = 6,
    parameter int N_OUT   = 4,
    parameter int SEL_W   = 2,
    parameter int SEL_LSB = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    stream_demux_nway_if.slave      sif,
    output logic [31:0]             bad_tag_cnt
`ifdef STREAM_DEMUX_DROP_EN
    ,
    output logic [31:0]             drop_cnt
`endif
);

    localparam logic [31:0] N_OUT_U = 32'(N_OUT);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_BAD  = 2'd2
`ifdef STREAM_DEMUX_DROP_EN
        ,
        ST_DROP = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] chan_q, chan_d;       // channel locked for the packet in flight
    logic             vld_q, vld_d;         // output register occupied
    logic [SEL_W-1:0] ch_q, ch_d;           // channel of the beat in the output register
    logic [DW-1:0]    data_q, data_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic [EW-1:0]    empty_q, empty_d;
    logic [31:0]      bad_q, bad_d;

    logic [SEL_W-1:0] tag_s;
    logic             tag_ok_s;
    logic             rdy_sel_s;
    logic             reg_free_s;
    logic             in_rdy_s;
    logic             fwd_s;
    logic             force_eop_s;
    logic [SEL_W-1:0] fwd_ch_s;
    logic             bad_inc_s;
    logic [N_OUT-1:0] out_valid_s;

`ifdef STREAM_DEMUX_DROP_EN
    logic             af_sel_s;
    logic             drop_inc_s;
    logic [31:0]      drop_q, drop_d;
`else
    logic             unused_af_s;
    assign unused_af_s = ^sif.out_almost_full;
`endif

    // Tag decode and selection of the sink handshake for the occupied register.
    always_comb begin
        tag_s     = sif.in_data[SEL_LSB +: SEL_W];
        tag_ok_s  = (32'(tag_s) < N_OUT_U);
        rdy_sel_s = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            rdy_sel_s = rdy_sel_s | ((ch_q == SEL_W'(k)) & sif.out_ready[k]);
        end
`ifdef STREAM_DEMUX_DROP_EN
        af_sel_s = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            af_sel_s = af_sel_s | ((tag_s == SEL_W'(k)) & sif.out_almost_full[k]);
        end
`endif
        reg_free_s = !vld_q || rdy_sel_s;
    end

    // Packet-level FSM: next state, input ready and forwarding decision.
    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        in_rdy_s    = 1'b1;
        fwd_s       = 1'b0;
        force_eop_s = 1'b0;
        fwd_ch_s    = chan_q;
        bad_inc_s   = 1'b0;
`ifdef STREAM_DEMUX_DROP_EN
        drop_inc_s  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                fwd_ch_s = tag_s;
                if (sif.in_sop) begin
                    if (!tag_ok_s) begin
                        in_rdy_s = 1'b1;
                        if (sif.in_valid) begin
                            bad_inc_s = 1'b1;
                            state_d   = sif.in_eop ? ST_IDLE : ST_BAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
`ifdef STREAM_DEMUX_DROP_EN
                    else if (af_sel_s) begin
                        in_rdy_s = 1'b1;
                        if (sif.in_valid) begin
                            drop_inc_s = 1'b1;
                            state_d    = sif.in_eop ? ST_IDLE : ST_DROP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
`endif
                    else begin
                        in_rdy_s = reg_free_s;
                        if (sif.in_valid && reg_free_s) begin
                            fwd_s   = 1'b1;
                            chan_d  = tag_s;
                            state_d = sif.in_eop ? ST_IDLE : ST_FWD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    // Stray mid-packet beat with no open packet: swallow it.
                    in_rdy_s = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_FWD: begin
                in_rdy_s = reg_free_s;
                if (sif.in_valid && reg_free_s) begin
                    fwd_s = 1'b1;
                    if (sif.in_eop || sif.in_sop) begin
                        // An unexpected SOP closes the current packet instead of opening one.
                        force_eop_s = sif.in_sop;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_FWD;
                    end
                end else begin
                    state_d = ST_FWD;
                end
            end
            ST_BAD: begin
                in_rdy_s = 1'b1;
                if (sif.in_valid && sif.in_eop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BAD;
                end
            end
`ifdef STREAM_DEMUX_DROP_EN
            ST_DROP: begin
                in_rdy_s = 1'b1;
                if (sif.in_valid && sif.in_eop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
`endif
            default: begin
                in_rdy_s = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Output register next state: load on forward, drain when the sink takes it.
    always_comb begin
        vld_d   = vld_q;
        ch_d    = ch_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        empty_d = empty_q;
        if (reg_free_s) begin
            vld_d = fwd_s;
            if (fwd_s) begin
                ch_d    = fwd_ch_s;
                data_d  = sif.in_data;
                sop_d   = sif.in_sop;
                eop_d   = sif.in_eop | force_eop_s;
                empty_d = sif.in_empty;
            end else begin
                ch_d = ch_q;
            end
        end else begin
            vld_d = vld_q;
        end
    end

    // Saturating event counters.
    always_comb begin
        if (bad_inc_s && (bad_q != CNT_MAX)) begin
            bad_d = bad_q + 32'd1;
        end else begin
            bad_d = bad_q;
        end
`ifdef STREAM_DEMUX_DROP_EN
        if (drop_inc_s && (drop_q != CNT_MAX)) begin
            drop_d = drop_q + 32'd1;
        end else begin
            drop_d = drop_q;
        end
`endif
    end

    // State, output register and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            chan_q  <= {SEL_W{1'b0}};
            vld_q   <= 1'b0;
            ch_q    <= {SEL_W{1'b0}};
            data_q  <= {DW{1'b0}};
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            empty_q <= {EW{1'b0}};
            bad_q   <= 32'd0;
`ifdef STREAM_DEMUX_DROP_EN
            drop_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            vld_q   <= vld_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            empty_q <= empty_d;
            bad_q   <= bad_d;
`ifdef STREAM_DEMUX_DROP_EN
            drop_q  <= drop_d;
`endif
        end
    end

    // Steer the shared valid bit to the channel of the registered beat.
    always_comb begin
        out_valid_s = {N_OUT{1'b0}};
        for (int k = 0; k < N_OUT; k++) begin
            out_valid_s[k] = vld_q && (ch_q == SEL_W'(k));
        end
    end

    assign sif.in_ready  = rst_n & in_rdy_s;
    assign sif.out_valid = out_valid_s;
    assign sif.out_data  = {N_OUT{data_q}};
    assign sif.out_sop   = {N_OUT{sop_q}};
    assign sif.out_eop   = {N_OUT{eop_q}};
    assign sif.out_empty = {N_OUT{empty_q}};
    assign bad_tag_cnt   = bad_q;
`ifdef STREAM_DEMUX_DROP_EN
    assign drop_cnt      = drop_q;
`endif

endmodule

// File: tb/tb_stream_demux_nway.sv
// Directed bench for stream_demux_nway (N_OUT=4, SEL_W=3, DW=32).
// Expected output beats are written by hand per test and compared with a
// log of beats the sinks actually took.
module tb_stream_demux_nway;

    localparam int DW    = 32;
    localparam int EW    = 2;
    localparam int N_OUT = 4;
    localparam int SEL_W = 3;

    typedef struct {
        int             cyc;
        logic [3:0]     vec;
        logic [DW-1:0]  data;
        logic           sop;
        logic           eop;
        logic [EW-1:0]  empty;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] bad_cnt;
`ifdef STREAM_DEMUX_DROP_EN
    logic [31:0] drop_cnt;
`endif

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    beat_t out_q[$];
    int    acc_q[$];

    stream_demux_nway_if #(.DW(DW), .EW(EW), .N_OUT(N_OUT)) sif ();

    stream_demux_nway #(
        .DW(DW), .EW(EW), .N_OUT(N_OUT), .SEL_W(SEL_W), .SEL_LSB(0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sif         (sif),
        .bad_tag_cnt (bad_cnt)
`ifdef STREAM_DEMUX_DROP_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log accepted input beats and beats taken by the sinks, with cycle stamps.
    always @(posedge clk) begin
        beat_t b;
        cyc <= cyc + 1;
        if (rst_n) begin
            if (sif.in_valid && sif.in_ready) acc_q.push_back(cyc);
            if (|(sif.out_valid & sif.out_ready)) begin
                b.cyc = cyc;
                b.vec = sif.out_valid;
                b.data = '0;
                b.sop = 1'b0;
                b.eop = 1'b0;
                b.empty = '0;
                for (int k = 0; k < N_OUT; k++) begin
                    if (sif.out_valid[k]) begin
                        b.data  = sif.out_data[k*DW +: DW];
                        b.sop   = sif.out_sop[k];
                        b.eop   = sif.out_eop[k];
                        b.empty = sif.out_empty[k*EW +: EW];
                    end
                end
                out_q.push_back(b);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e,
                             input logic [EW-1:0] em, output int waits);
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_data  = d;
        sif.in_sop   = s;
        sif.in_eop   = e;
        sif.in_empty = em;
        waits = 0;
        #1;
        while (!sif.in_ready && waits < 50) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check_eq("accept", {63'd0, sif.in_ready}, 64'd1);
        @(posedge clk);
    endtask

    task automatic go_idle();
        @(negedge clk);
        sif.in_valid = 1'b0;
        sif.in_sop   = 1'b0;
        sif.in_eop   = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_logs();
        out_q.delete();
        acc_q.delete();
    endtask

    task automatic chk_beat(input string tag, input int i, input logic [3:0] vec,
                            input logic [DW-1:0] d, input logic s, input logic e);
        check_eq({tag, "_vec"},  {60'd0, out_q[i].vec}, {60'd0, vec});
        check_eq({tag, "_data"}, {32'd0, out_q[i].data}, {32'd0, d});
        check_eq({tag, "_sop"},  {63'd0, out_q[i].sop}, {63'd0, s});
        check_eq({tag, "_eop"},  {63'd0, out_q[i].eop}, {63'd0, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data  = '0;
        sif.in_sop   = 1'b0;
        sif.in_eop   = 1'b0;
        sif.in_empty = '0;
        sif.out_ready = 4'b1111;
        sif.out_almost_full = 4'b0000;

        // Reset state
        #1;
        check_eq("rst_in_ready", {63'd0, sif.in_ready}, 64'd0);
        check_eq("rst_out_valid", {60'd0, sif.out_valid}, 64'd0);
        check_eq("rst_bad_cnt", {32'd0, bad_cnt}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("idle_in_ready", {63'd0, sif.in_ready}, 64'd1);
        repeat (2) @(negedge clk);

        // 3-beat packet on tag 2
        clear_logs();
        send_beat(32'hA5A5_0002, 1'b1, 1'b0, 2'd1, w);
        send_beat(32'h1111_1111, 1'b0, 1'b0, 2'd0, w);
        send_beat(32'h2222_2222, 1'b0, 1'b1, 2'd3, w);
        go_idle();
        check_eq("t2_count", out_q.size(), 64'd3);
        chk_beat("t2_b0", 0, 4'b0100, 32'hA5A5_0002, 1'b1, 1'b0);
        chk_beat("t2_b1", 1, 4'b0100, 32'h1111_1111, 1'b0, 1'b0);
        chk_beat("t2_b2", 2, 4'b0100, 32'h2222_2222, 1'b0, 1'b1);
        check_eq("t2_empty0", {62'd0, out_q[0].empty}, 64'd1);
        check_eq("t2_empty2", {62'd0, out_q[2].empty}, 64'd3);
        check_eq("t2_lat", out_q[0].cyc, acc_q[0] + 1);
        check_eq("t2_consec", out_q[2].cyc, out_q[0].cyc + 2);

        // Back-to-back single-beat packets, tags 0,1,3,0
        clear_logs();
        send_beat(32'h0000_1000, 1'b1, 1'b1, 2'd0, w);
        send_beat(32'h0000_2001, 1'b1, 1'b1, 2'd0, w);
        send_beat(32'h0000_3003, 1'b1, 1'b1, 2'd0, w);
        send_beat(32'h0000_4000, 1'b1, 1'b1, 2'd0, w);
        go_idle();
        check_eq("b2b_count", out_q.size(), 64'd4);
        chk_beat("b2b_0", 0, 4'b0001, 32'h0000_1000, 1'b1, 1'b1);
        chk_beat("b2b_1", 1, 4'b0010, 32'h0000_2001, 1'b1, 1'b1);
        chk_beat("b2b_2", 2, 4'b1000, 32'h0000_3003, 1'b1, 1'b1);
        chk_beat("b2b_3", 3, 4'b0001, 32'h0000_4000, 1'b1, 1'b1);
        check_eq("b2b_nobubble", out_q[3].cyc, out_q[0].cyc + 3);

        // Out-of-range tag 5, 4 beats, then a tag-1 packet
        clear_logs();
        send_beat(32'h0000_0005, 1'b1, 1'b0, 2'd0, w);
        check_eq("bad_rdy0", w, 64'd0);
        send_beat(32'hBAD0_0001, 1'b0, 1'b0, 2'd0, w);
        check_eq("bad_rdy1", w, 64'd0);
        send_beat(32'hBAD0_0002, 1'b0, 1'b0, 2'd0, w);
        check_eq("bad_rdy2", w, 64'd0);
        send_beat(32'hBAD0_0003, 1'b0, 1'b1, 2'd0, w);
        check_eq("bad_rdy3", w, 64'd0);
        go_idle();
        check_eq("bad_none_out", out_q.size(), 64'd0);
        check_eq("bad_cnt", {32'd0, bad_cnt}, 64'd1);
        send_beat(32'h0000_5001, 1'b1, 1'b1, 2'd2, w);
        go_idle();
        check_eq("after_bad_count", out_q.size(), 64'd1);
        chk_beat("after_bad", 0, 4'b0010, 32'h0000_5001, 1'b1, 1'b1);

        // Backpressure on channel 1 for 5 cycles mid-packet
        clear_logs();
        fork
            begin
                send_beat(32'hC000_0001, 1'b1, 1'b0, 2'd0, w);
                send_beat(32'hC111_1111, 1'b0, 1'b0, 2'd0, w);
                send_beat(32'hC222_2222, 1'b0, 1'b0, 2'd0, w);
                send_beat(32'hC333_3333, 1'b0, 1'b1, 2'd0, w);
            end
            begin
                for (int t = 0; t < 40 && acc_q.size() < 2; t++) @(negedge clk);
                sif.out_ready[1] = 1'b0;
                for (int t = 0; t < 5; t++) begin
                    #1;
                    check_eq("bp_in_ready", {63'd0, sif.in_ready}, 64'd0);
                    check_eq("bp_hold_data", {32'd0, sif.out_data[DW +: DW]}, 64'hC111_1111);
                    check_eq("bp_valid", {60'd0, sif.out_valid}, 64'b0010);
                    @(negedge clk);
                end
                sif.out_ready[1] = 1'b1;
            end
        join
        go_idle();
        check_eq("bp_count", out_q.size(), 64'd4);
        chk_beat("bp_0", 0, 4'b0010, 32'hC000_0001, 1'b1, 1'b0);
        chk_beat("bp_1", 1, 4'b0010, 32'hC111_1111, 1'b0, 1'b0);
        chk_beat("bp_2", 2, 4'b0010, 32'hC222_2222, 1'b0, 1'b0);
        chk_beat("bp_3", 3, 4'b0010, 32'hC333_3333, 1'b0, 1'b1);

        // SOP inside an open packet closes it; stray beat discarded; next packet delivered
        clear_logs();
        send_beat(32'hD000_0001, 1'b1, 1'b0, 2'd0, w);
        send_beat(32'hD111_1111, 1'b0, 1'b0, 2'd0, w);
        send_beat(32'hD000_0003, 1'b1, 1'b0, 2'd0, w);
        send_beat(32'hD333_3333, 1'b0, 1'b1, 2'd0, w);
        send_beat(32'hD000_0000, 1'b1, 1'b1, 2'd0, w);
        go_idle();
        check_eq("sopfwd_count", out_q.size(), 64'd4);
        check_eq("sopfwd_vec", {60'd0, out_q[2].vec}, 64'b0010);
        check_eq("sopfwd_data", {32'd0, out_q[2].data}, 64'hD000_0003);
        check_eq("sopfwd_eop", {63'd0, out_q[2].eop}, 64'd1);
        chk_beat("sopfwd_next", 3, 4'b0001, 32'hD000_0000, 1'b1, 1'b1);

        // Almost-full on channel 3 at SOP
        clear_logs();
        sif.out_almost_full = 4'b1000;
        send_beat(32'hE000_0003, 1'b1, 1'b0, 2'd0, w);
        sif.out_almost_full = 4'b0000;
        send_beat(32'hE111_1111, 1'b0, 1'b1, 2'd0, w);
        go_idle();
`ifdef STREAM_DEMUX_DROP_EN
        check_eq("drop_none_out", out_q.size(), 64'd0);
        check_eq("drop_cnt", {32'd0, drop_cnt}, 64'd1);
`else
        check_eq("af_count", out_q.size(), 64'd2);
        chk_beat("af_0", 0, 4'b1000, 32'hE000_0003, 1'b1, 1'b0);
        chk_beat("af_1", 1, 4'b1000, 32'hE111_1111, 1'b0, 1'b1);
`endif

        // Reset during beat 2 of a 4-beat packet
        clear_logs();
        send_beat(32'hF000_0002, 1'b1, 1'b0, 2'd0, w);
        send_beat(32'hF111_1111, 1'b0, 1'b0, 2'd0, w);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {60'd0, sif.out_valid}, 64'd0);
        check_eq("mid_rst_ready", {63'd0, sif.in_ready}, 64'd0);
        check_eq("mid_rst_bad", {32'd0, bad_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(32'hF222_2222, 1'b0, 1'b0, 2'd0, w);
        send_beat(32'hF333_3333, 1'b0, 1'b1, 2'd0, w);
        go_idle();
        send_beat(32'hF000_0000, 1'b1, 1'b1, 2'd0, w);
        go_idle();
        check_eq("rst_pkt_count", out_q.size(), 64'd2);
        chk_beat("rst_b0", 0, 4'b0100, 32'hF000_0002, 1'b1, 1'b0);
        chk_beat("rst_next", 1, 4'b0001, 32'hF000_0000, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_demux_nway.md
STREAM_DEMUX_NWAY -- requirements
Module: stream_demux_nway

Interface
REQ-001 Parameter DW, default 512: data width in bits.
REQ-002 Parameter EW, default 6: empty-field width; EW = log2(DW/8).
REQ-003 Parameter N_OUT, default 4, legal range 2..16: number of output channels.
REQ-004 Parameter SEL_W, default 2: channel-tag width; SEL_W >= ceil(log2(N_OUT)).
REQ-005 Parameter SEL_LSB, default 0: bit position of the channel tag in the SOP beat's in_data.
REQ-006 Clk  in  1  single clock; all logic is on the rising edge.
REQ-007 Rst_n  in  1  asynchronous active-low reset.
REQ-008 in_data/in_valid/in_sop/in_eop/in_empty  in  DW/1/1/1/EW  Avalon-ST input beat.
REQ-009 in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-010 out_data  out  N_OUT*DW  flattened; channel k occupies bits [k*DW +: DW].
REQ-011 out_valid/out_sop/out_eop  out  N_OUT each  per-channel strobes.
REQ-012 out_empty  out  N_OUT*EW  flattened, per channel.
REQ-013 out_ready  in  N_OUT  per-channel sink ready.
REQ-014 out_almost_full  in  N_OUT  per-channel sink almost-full.
REQ-015 bad_tag_cnt  out  32  count of packets whose tag is >= N_OUT.

Function
REQ-016 A single output register stage holds data, sop, eop, empty, a valid bit (vld_q) and a channel index (ch_q); latency from input accept to out_valid is exactly 1 cycle.
REQ-017 out_valid[k] = vld_q && (ch_q == k); out_data, out_empty, out_sop and out_eop of all channels are driven from the shared register, and only the valid strobe is steered.
REQ-018 The register is free when (!vld_q || out_ready[ch_q]); in_ready is 1 in IDLE, DROP and BAD states, and equals "register free" in FWD state and for a SOP beat accepted in IDLE.
REQ-019 The FSM has states IDLE, FWD, DROP and BAD; the reset state is IDLE.
REQ-020 IDLE, SOP beat: tag = in_data[SEL_LSB +: SEL_W]. If tag >= N_OUT, go to BAD. Otherwise lock chan_q = tag and forward the beat; if the beat is not EOP, go to FWD.
REQ-021 IDLE, non-SOP beat: accept and discard it; the state does not change.
REQ-022 FWD: forward accepted beats on chan_q; an accepted EOP beat returns the FSM to IDLE.
REQ-023 A SOP beat arriving in FWD is treated as the EOP of the current packet, is forwarded with out_eop forced to 1, and returns the FSM to IDLE; it is not re-parsed.
REQ-024 BAD: discard beats until EOP, then return to IDLE. bad_tag_cnt increments once per bad packet, at its SOP, and saturates at 0xFFFF_FFFF.
REQ-025 A single-beat packet (SOP and EOP in one beat) returns the FSM to IDLE in the cycle it is accepted.
REQ-026 Back-to-back packets to different channels carry no bubble: the SOP beat of packet n+1 may be accepted in the cycle after the EOP beat of packet n.
REQ-027 Output data stays stable while out_valid[k] && !out_ready[k].

Reset
REQ-028 Rst_n low asynchronously clears state to IDLE and vld_q, chan_q, ch_q, bad_tag_cnt and drop_cnt to 0; all out_valid bits go to 0 immediately.
REQ-029 Reset asserted mid-packet abandons the packet; after release, beats are discarded until the next SOP.
REQ-030 in_ready is 0 while Rst_n is low.

Configuration
REQ-031 Macro STREAM_DEMUX_DROP_EN, when defined: at an IDLE SOP with a valid tag and out_almost_full[tag] = 1, the whole packet is discarded via state DROP (in_ready = 1 until EOP), and a 32-bit saturating output drop_cnt increments once per dropped packet.
REQ-032 STREAM_DEMUX_DROP_EN, when not defined: out_almost_full is ignored, the DROP state and the drop_cnt port do not exist, and backpressure is only via out_ready.

Verification
REQ-033 N_OUT=4; 3-beat packet with tag 2, all out_ready=1 -> out_valid=4'b0100 for 3 consecutive cycles starting 1 cycle after the first accept; sop on beat 1, eop on beat 3; empty passes through unchanged.
REQ-034 Packets with tags 0,1,3,0 sent back-to-back, 1 beat each -> out_valid sequence 0001, 0010, 1000, 0001 with no idle cycles.
REQ-035 Tag 5 with SEL_W=3 and N_OUT=4, 4-beat packet -> no out_valid, in_ready=1 throughout, bad_tag_cnt=1; the next packet with tag 1 is delivered.
REQ-036 out_ready[1]=0 for 5 cycles mid-packet on channel 1 -> out_data held stable, in_ready=0 while the register is full, no beat lost or duplicated.
REQ-037 With STREAM_DEMUX_DROP_EN defined: out_almost_full[3]=1 at the SOP of a tag-3 packet -> packet absent on all outputs, drop_cnt=1. Without the macro: same stimulus -> packet delivered on channel 3.
REQ-038 Rst_n pulsed low during beat 2 of a 4-beat packet -> out_valid=0 at once; beats 3–4 are discarded after release; the next SOP packet is delivered normally.
